// File: rtl/ringosc_pkg.sv
// Shared types and default widths for the ring-oscillator frequency meter.
package ringosc_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        GATE   = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int SETTLE_CYC = 3;

    localparam int DEF_NUM_CH = 4;
    localparam int DEF_GATE_W = 12;
    localparam int DEF_CNT_W  = 16;

endpackage

// File: rtl/ringosc_freq_meter_if.sv
// Control/result bundle between the frequency meter and its host logic.
interface ringosc_freq_meter_if
    import ringosc_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int GATE_W = DEF_GATE_W,
    parameter int CNT_W  = DEF_CNT_W
);
    localparam int CH_W = $clog2(NUM_CH);

    logic              start;
    logic [CH_W-1:0]   ch_sel;
    logic [GATE_W-1:0] gate_len;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  count;
    logic              overflow;

    modport master (
        output start, ch_sel, gate_len,
        input  busy, done, count, overflow
    );

    modport slave (
        input  start, ch_sel, gate_len,
        output busy, done, count, overflow
    );

endinterface

// File: rtl/ringosc_sync.sv
// Two-flop synchroniser bringing one free-running oscillator into clk.
module ringosc_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);
    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            dout <= 1'b0;
        end else begin
            meta <= din;
            dout <= meta;
        end
    end

endmodule

// File: rtl/ringosc_freq_meter.sv
// Gated rising-edge counter for one of NUM_CH ring oscillators.
// Define RINGOSC_AUTORESTART_EN to add the auto_en back-to-back measurement mode.
//
// state  | meaning
// IDLE   | waiting for start
// SETTLE | 3 cycles flushing mux/edge flop, accumulator cleared
// GATE   | gate_len cycles counting edges
// DONE   | result published, done pulse
module ringosc_freq_meter
    import ringosc_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int GATE_W = DEF_GATE_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] ro_in,
`ifdef RINGOSC_AUTORESTART_EN
    input  logic              auto_en,
`endif
    ringosc_freq_meter_if.slave bus
);
    localparam int CH_W = $clog2(NUM_CH);
    localparam logic [CNT_W-1:0]  CNT_MAX     = '1;
    localparam logic [GATE_W-1:0] SETTLE_LOAD = GATE_W'(SETTLE_CYC - 1);

    state_t            state, state_next;
    logic [NUM_CH-1:0] ro_sync;
    logic [CH_W-1:0]   ch_lat;
    logic [GATE_W-1:0] gate_lat;
    logic [GATE_W-1:0] tmr;
    logic              tmr_zero;
    logic              mux_out, mux_q, rise;
    logic [CNT_W-1:0]  acc, acc_next;
    logic              ovf, ovf_next;
    logic              auto_go;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_sync
        ringosc_sync u_sync (
            .clk  (clk),
            .rst_n(rst_n),
            .din  (ro_in[i]),
            .dout (ro_sync[i])
        );
    end

`ifdef RINGOSC_AUTORESTART_EN
    assign auto_go = auto_en;
`else
    assign auto_go = 1'b0;
`endif

    assign mux_out  = ro_sync[ch_lat];
    assign rise     = mux_out & ~mux_q;
    assign tmr_zero = (tmr == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        bus.busy   = 1'b0;
        bus.done   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) state_next = SETTLE;
            end
            SETTLE: begin
                bus.busy = 1'b1;
                if (tmr_zero) state_next = (gate_lat == '0) ? DONE : GATE;
            end
            GATE: begin
                bus.busy = 1'b1;
                if (tmr_zero) state_next = DONE;
            end
            DONE: begin
                bus.done   = 1'b1;
                bus.busy   = auto_go;
                state_next = auto_go ? SETTLE : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Saturating accumulator; ovf is sticky once an edge arrives at full scale.
    always_comb begin
        acc_next = acc;
        ovf_next = ovf;
        if (state == SETTLE) begin
            acc_next = '0;
            ovf_next = 1'b0;
        end else if (state == GATE && rise) begin
            if (acc == CNT_MAX) ovf_next = 1'b1;
            else                acc_next = acc + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch_lat       <= '0;
            gate_lat     <= '0;
            tmr          <= '0;
            mux_q        <= 1'b0;
            acc          <= '0;
            ovf          <= 1'b0;
            bus.count    <= '0;
            bus.overflow <= 1'b0;
        end else begin
            mux_q <= mux_out;
            acc   <= acc_next;
            ovf   <= ovf_next;
            if (state == IDLE && bus.start) begin
                ch_lat   <= (32'(bus.ch_sel) < NUM_CH) ? bus.ch_sel : '0;
                gate_lat <= bus.gate_len;
            end
            if (state != SETTLE && state_next == SETTLE)
                tmr <= SETTLE_LOAD;
            else if (state == SETTLE && tmr_zero)
                tmr <= (gate_lat == '0) ? '0 : gate_lat - GATE_W'(1);
            else if ((state == SETTLE || state == GATE) && !tmr_zero)
                tmr <= tmr - GATE_W'(1);
            // Publish on entry to DONE so count is valid while done is high.
            if (state != DONE && state_next == DONE) begin
                bus.count    <= acc_next;
                bus.overflow <= ovf_next;
            end
        end
    end

endmodule

// File: tb/tb_ringosc_freq_meter.sv
// Directed bench for ringosc_freq_meter: hand-computed latencies and edge counts.
`timescale 1ns/1ps
module tb_ringosc_freq_meter;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    wire  [3:0] ro;
    int         half_p [4] = '{5, 4, 20, 7};
    int         errors = 0;
    int         checks = 0;
    int         lat, nd, first, saved;
`ifdef RINGOSC_AUTORESTART_EN
    logic       auto_en = 1'b0;
`endif

    ringosc_freq_meter_if #(.NUM_CH(4), .GATE_W(12), .CNT_W(16)) bus   ();
    ringosc_freq_meter_if #(.NUM_CH(4), .GATE_W(12), .CNT_W(4))  bus_s ();

    ringosc_freq_meter #(.NUM_CH(4), .GATE_W(12), .CNT_W(16)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .ro_in  (ro),
`ifdef RINGOSC_AUTORESTART_EN
        .auto_en(auto_en),
`endif
        .bus    (bus)
    );

    ringosc_freq_meter #(.NUM_CH(4), .GATE_W(12), .CNT_W(4)) dut_sat (
        .clk    (clk),
        .rst_n  (rst_n),
        .ro_in  (ro),
`ifdef RINGOSC_AUTORESTART_EN
        .auto_en(1'b0),
`endif
        .bus    (bus_s)
    );

    always #5 clk = ~clk;

    // Oscillator edges land 2 ns before a clk edge, never on it.
    for (genvar g = 0; g < 4; g++) begin : g_osc
        logic q = 1'b0;
        initial begin
            #3;
            forever begin
                #(half_p[g] * 10);
                q = ~q;
            end
        end
        assign ro[g] = q;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_rng(input string tag, input int obs, input int lo, input int hi);
        checks++;
        assert ((obs >= lo && obs <= hi) === 1'b1) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Leaves the bench in the cycle after acceptance; inputs then scrambled.
    task automatic pulse_start(input logic [1:0] ch, input logic [11:0] g);
        bus.ch_sel   = ch;
        bus.gate_len = g;
        bus.start    = 1'b1;
        step(1);
        bus.start    = 1'b0;
        bus.ch_sel   = ch + 2'd1;
        bus.gate_len = 12'd7;
    endtask

    task automatic wait_done(input int max_cyc, output int l);
        l = 1;
        while (bus.done !== 1'b1 && l < max_cyc) begin
            step(1);
            l++;
        end
        if (bus.done !== 1'b1) l = -1;
    endtask

    task automatic wait_done_s(input int max_cyc, output int l);
        l = 1;
        while (bus_s.done !== 1'b1 && l < max_cyc) begin
            step(1);
            l++;
        end
        if (bus_s.done !== 1'b1) l = -1;
    endtask

    task automatic count_dones(input int n, output int cnt);
        cnt = 0;
        repeat (n) begin
            step(1);
            if (bus.done === 1'b1) cnt++;
        end
    endtask

    initial begin
        bus.start      = 1'b0;
        bus.ch_sel     = '0;
        bus.gate_len   = '0;
        bus_s.start    = 1'b0;
        bus_s.ch_sel   = '0;
        bus_s.gate_len = '0;

        // Reset with oscillators running, then idle
        step(5);
        rst_n = 1'b1;
        count_dones(20, nd);
        chk("idle_busy", 32'(bus.busy), 32'd0);
        chk("idle_done", 32'(bus.done), 32'd0);
        chk("idle_count", 32'(bus.count), 32'd0);
        chk("idle_ovf", 32'(bus.overflow), 32'd0);
        chk("idle_no_done", 32'(nd), 32'd0);

        // Basic count: ch1 period 8, gate 64
        pulse_start(2'd1, 12'd64);
        chk("basic_busy", 32'(bus.busy), 32'd1);
        wait_done(200, lat);
        chk("basic_lat", 32'(lat), 32'd68);
        chk("basic_busy_done", 32'(bus.busy), 32'd0);
        chk_rng("basic_count", int'(bus.count), 7, 9);
        chk("basic_ovf", 32'(bus.overflow), 32'd0);
        saved = int'(bus.count);
        step(1);
        chk("basic_hold", 32'(bus.count), 32'(saved));
        chk("basic_done_pulse", 32'(bus.done), 32'd0);

        // Mid-run reset at +30 of a 100-cycle gate
        pulse_start(2'd0, 12'd100);
        step(29);
        rst_n = 1'b0;
        #2;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_count", 32'(bus.count), 32'd0);
        chk("rst_ovf", 32'(bus.overflow), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        step(2);
        rst_n = 1'b1;
        count_dones(150, nd);
        chk("rst_no_done", 32'(nd), 32'd0);

        // Channel isolation: ch2 (period 40) then ch0 (period 10)
        pulse_start(2'd2, 12'd400);
        wait_done(600, lat);
        chk("ch2_lat", 32'(lat), 32'd404);
        chk_rng("ch2_count", int'(bus.count), 9, 11);
        step(1);
        pulse_start(2'd0, 12'd400);
        wait_done(600, lat);
        chk("ch0_lat", 32'(lat), 32'd404);
        chk_rng("ch0_count", int'(bus.count), 39, 41);

        // Zero gate
        step(1);
        pulse_start(2'd1, 12'd0);
        wait_done(20, lat);
        chk("zero_lat", 32'(lat), 32'd4);
        chk("zero_count", 32'(bus.count), 32'd0);
        chk("zero_ovf", 32'(bus.overflow), 32'd0);

        // Start raised during the DONE cycle is dropped
        bus.start = 1'b1;
        step(1);
        bus.start = 1'b0;
        chk("done_start_busy", 32'(bus.busy), 32'd0);
        count_dones(10, nd);
        chk("done_start_no_done", 32'(nd), 32'd0);

        // Start while busy is ignored
        pulse_start(2'd3, 12'd100);
        first = -1;
        nd    = 0;
        for (int n = 1; n <= 200; n++) begin
            bus.start = (n == 10);
            if (bus.done === 1'b1) begin
                nd++;
                if (first < 0) first = n;
            end
            step(1);
        end
        bus.start = 1'b0;
        chk("busy_start_first", 32'(first), 32'd104);
        chk("busy_start_single", 32'(nd), 32'd1);

        // Saturation on the 4-bit instance: ch0 period 4, gate 200
        half_p[0] = 2;
        step(10);
        bus_s.ch_sel   = 2'd0;
        bus_s.gate_len = 12'd200;
        bus_s.start    = 1'b1;
        step(1);
        bus_s.start    = 1'b0;
        wait_done_s(300, lat);
        chk("sat_lat", 32'(lat), 32'd204);
        chk("sat_count", 32'(bus_s.count), 32'd15);
        chk("sat_ovf", 32'(bus_s.overflow), 32'd1);
        step(1);
        bus_s.gate_len = 12'd8;
        bus_s.start    = 1'b1;
        step(1);
        bus_s.start    = 1'b0;
        wait_done_s(50, lat);
        chk("sat2_lat", 32'(lat), 32'd12);
        chk_rng("sat2_count", int'(bus_s.count), 1, 3);
        chk("sat2_ovf", 32'(bus_s.overflow), 32'd0);

`ifdef RINGOSC_AUTORESTART_EN
        // Auto-restart: done every 20 cycles, busy drops on the first done after auto_en low
        step(1);
        auto_en = 1'b1;
        pulse_start(2'd1, 12'd16);
        wait_done(50, lat);
        chk("auto_lat0", 32'(lat), 32'd20);
        chk("auto_busy0", 32'(bus.busy), 32'd1);
        step(1);
        wait_done(50, lat);
        chk("auto_lat1", 32'(lat), 32'd20);
        chk("auto_busy1", 32'(bus.busy), 32'd1);
        chk_rng("auto_count1", int'(bus.count), 1, 3);
        step(6);
        auto_en = 1'b0;
        wait_done(50, lat);
        chk("auto_lat2", 32'(lat), 32'd15);
        chk("auto_busy_last", 32'(bus.busy), 32'd0);
        step(1);
        chk("auto_idle_busy", 32'(bus.busy), 32'd0);
        count_dones(30, nd);
        chk("auto_stopped", 32'(nd), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
